writeback_arbiter: RTL and testbench

- Shares the single register-file write port between two requesters:
  - the execute-stage result path (ALU);
  - the late-returning memory load path.
- Memory returns always win the port. ALU results that lose arbitration are held in a small in-order FIFO and drained on idle cycles.
- Sits between execute/memory and the register file. Drives the register file's write_address/write_data/write_enable directly, as registered outputs.

---
 rtl/writeback_arbiter_pkg.sv | 19 +
 rtl/writeback_arbiter_wb_fifo.sv | 88 ++++++++
 rtl/writeback_arbiter.sv | 115 +++++++++++
 tb/tb_writeback_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   WBA_DATA_SIZE  : register data width
//   WBA_GPR_SIZE   : register address width
//   WBA_FIFO_DEPTH : ALU holding-buffer entries (power of two, >= 2)
//   wba_sel_e      : per-cycle write-port source select
package writeback_arbiter_pkg;

  localparam int unsigned WBA_DATA_SIZE  = 32;
  localparam int unsigned WBA_GPR_SIZE   = 5;
  localparam int unsigned WBA_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    WBA_SEL_NONE,
    WBA_SEL_MEM,
    WBA_SEL_FIFO,
    WBA_SEL_ALU
  } wba_sel_e;

endpackage

// File: rtl/writeback_arbiter_wb_fifo.sv
// wb_fifo: in-order circular buffer for ALU results that lost the write port.
// Each entry carries a valid bit so a younger memory return can squash it.
//   clk, reset         : clock, async active-high reset
//   flush              : drop every entry (wins over push/pop)
//   push, push_valid   : enqueue {push_dest, push_data} with the given valid bit
//   pop                : discard the head entry
//   inv_en, inv_dest   : clear valid on every entry whose destination matches
//   head_dest/data/valid : head entry
//   count              : occupancy
module wb_fifo
  import writeback_arbiter_pkg::*;
#(
  parameter int unsigned DATA_SIZE = WBA_DATA_SIZE,
  parameter int unsigned GPR_SIZE  = WBA_GPR_SIZE,
  parameter int unsigned DEPTH     = WBA_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       push_valid,
  input  logic [GPR_SIZE-1:0]        push_dest,
  input  logic [DATA_SIZE-1:0]       push_data,
  input  logic                       pop,
  input  logic                       inv_en,
  input  logic [GPR_SIZE-1:0]        inv_dest,
  output logic [GPR_SIZE-1:0]        head_dest,
  output logic [DATA_SIZE-1:0]       head_data,
  output logic                       head_valid,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [GPR_SIZE-1:0]  dest_q [DEPTH];
  logic [DATA_SIZE-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]     valid_q;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      valid_q <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      valid_q <= '0;
    end else begin
      if (inv_en) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (dest_q[PTR_W'(i)] == inv_dest) valid_q[PTR_W'(i)] <= 1'b0;
        end
      end
      if (pop) begin
        valid_q[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + 1'b1;
      end
      // Push comes last so its valid bit overrides the invalidate sweep;
      // the caller already folds a same-cycle match into push_valid.
      if (push) begin
        valid_q[wr_ptr] <= push_valid;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      dest_q[wr_ptr] <= push_dest;
      data_q[wr_ptr] <= push_data;
    end
  end

  assign head_dest  = dest_q[rd_ptr];
  assign head_data  = data_q[rd_ptr];
  assign head_valid = valid_q[rd_ptr];

endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: shares the single register-file write port between the
// ALU result path and the memory load-return path. Memory always wins; ALU
// results that lose are buffered in order and drained on idle cycles.
//   clk, reset                 : clock, async active-high reset
//   alu_valid/destination/result, alu_ready : ALU offer handshake
//   mem_valid/destination/data : load return, always accepted
//   flush                      : discard buffered ALU entries
//   write_address/data/enable  : registered register-file write port
//   buffer_count               : holding-buffer occupancy
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int unsigned DATA_SIZE  = WBA_DATA_SIZE,
  parameter int unsigned GPR_SIZE   = WBA_GPR_SIZE,
  parameter int unsigned FIFO_DEPTH = WBA_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          alu_valid,
  input  logic [GPR_SIZE-1:0]           alu_destination,
  input  logic [DATA_SIZE-1:0]          alu_result,
  output logic                          alu_ready,
  input  logic                          mem_valid,
  input  logic [GPR_SIZE-1:0]           mem_destination,
  input  logic [DATA_SIZE-1:0]          mem_data,
  input  logic                          flush,
  output logic [GPR_SIZE-1:0]           write_address,
  output logic [DATA_SIZE-1:0]          write_data,
  output logic                          write_enable,
  output logic [$clog2(FIFO_DEPTH):0]   buffer_count
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  wba_sel_e             sel;
  logic                 fifo_empty;
  logic                 alu_accept;
  logic                 push;
  logic                 push_valid;
  logic                 pop;
  logic [GPR_SIZE-1:0]  head_dest;
  logic [DATA_SIZE-1:0] head_data;
  logic                 head_valid;
  logic [GPR_SIZE-1:0]  sel_dest;
  logic [DATA_SIZE-1:0] sel_data;
  logic                 sel_valid;
  logic                 do_write;

  assign alu_ready  = (buffer_count != CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (buffer_count == '0);
  // A flushed cycle drops the ALU offer entirely (neither bypassed nor queued).
  assign alu_accept = alu_valid && alu_ready && !flush;

  always_comb begin
    sel = WBA_SEL_NONE;
    if (mem_valid)                   sel = WBA_SEL_MEM;
    else if (!flush && !fifo_empty)  sel = WBA_SEL_FIFO;
    else if (alu_accept)             sel = WBA_SEL_ALU;
  end

  assign push = alu_accept && (mem_valid || !fifo_empty);
  assign pop  = (sel == WBA_SEL_FIFO);
  // The load return is younger than a same-cycle ALU offer to the same register.
  assign push_valid = !(mem_valid && (alu_destination == mem_destination));

  always_comb begin
    sel_dest  = '0;
    sel_data  = '0;
    sel_valid = 1'b0;
    case (sel)
      WBA_SEL_MEM:  begin sel_dest = mem_destination; sel_data = mem_data;   sel_valid = 1'b1;       end
      WBA_SEL_FIFO: begin sel_dest = head_dest;       sel_data = head_data;  sel_valid = head_valid; end
      WBA_SEL_ALU:  begin sel_dest = alu_destination; sel_data = alu_result; sel_valid = 1'b1;       end
      default:      ;
    endcase
  end

  assign do_write = sel_valid && (sel_dest != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_enable  <= 1'b0;
      write_address <= '0;
      write_data    <= '0;
    end else begin
      write_enable <= do_write;
      if (do_write) begin
        write_address <= sel_dest;
        write_data    <= sel_data;
      end
    end
  end

  wb_fifo #(
    .DATA_SIZE (DATA_SIZE),
    .GPR_SIZE  (GPR_SIZE),
    .DEPTH     (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .push       (push),
    .push_valid (push_valid),
    .push_dest  (alu_destination),
    .push_data  (alu_result),
    .pop        (pop),
    .inv_en     (mem_valid),
    .inv_dest   (mem_destination),
    .head_dest  (head_dest),
    .head_data  (head_data),
    .head_valid (head_valid),
    .count      (buffer_count)
  );

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned FD = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          alu_valid = 1'b0;
  logic [AW-1:0] alu_destination = '0;
  logic [DW-1:0] alu_result = '0;
  logic          alu_ready;
  logic          mem_valid = 1'b0;
  logic [AW-1:0] mem_destination = '0;
  logic [DW-1:0] mem_data = '0;
  logic          flush = 1'b0;
  logic [AW-1:0] write_address;
  logic [DW-1:0] write_data;
  logic          write_enable;
  logic [2:0]    buffer_count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Scoreboard of expected register-file writes {address, data}, in order.
  logic [AW+DW-1:0] sb [$];

  writeback_arbiter #(
    .DATA_SIZE  (DW),
    .GPR_SIZE   (AW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .alu_valid       (alu_valid),
    .alu_destination (alu_destination),
    .alu_result      (alu_result),
    .alu_ready       (alu_ready),
    .mem_valid       (mem_valid),
    .mem_destination (mem_destination),
    .mem_data        (mem_data),
    .flush           (flush),
    .write_address   (write_address),
    .write_data      (write_data),
    .write_enable    (write_enable),
    .buffer_count    (buffer_count)
  );

  always #5 clk = ~clk;

  // Every observed write is matched against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && write_enable) begin
      logic [AW+DW-1:0] exp;
      total_cnt++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_write: got r%0d=%h, required no write", write_address, write_data);
      end else begin
        exp = sb.pop_front();
        if ({write_address, write_data} !== exp)
          $display("FAIL sb_write: got r%0d=%h, required r%0d=%h",
                   write_address, write_data, exp[AW+DW-1:DW], exp[DW-1:0]);
        else
          pass_cnt++;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle();
    repeat (2) tick();
    total_cnt++;
    if ({write_enable, write_address, write_data} !== '0)
      $display("FAIL reset_outputs: got we=%b addr=%0d data=%h, required all 0", write_enable, write_address, write_data);
    else pass_cnt++;
    total_cnt++;
    if (buffer_count !== 3'd0) $display("FAIL reset_count: got %0d, required 0", buffer_count);
    else pass_cnt++;
    reset = 1'b0;
    tick();
    total_cnt++;
    if (alu_ready !== 1'b1) $display("FAIL reset_ready: got %b, required 1", alu_ready);
    else pass_cnt++;
  endtask

  task automatic test_alu_only;
    alu_valid = 1'b1; alu_destination = 5'd3; alu_result = 32'hA5;
    sb.push_back({5'd3, 32'hA5});
    tick();
    idle();
    total_cnt++;
    if (!(write_enable === 1'b1 && write_address === 5'd3 && write_data === 32'hA5))
      $display("FAIL alu_only_write: got we=%b r%0d=%h, required we=1 r3=000000a5", write_enable, write_address, write_data);
    else pass_cnt++;
    total_cnt++;
    if (buffer_count !== 3'd0) $display("FAIL alu_only_count: got %0d, required 0", buffer_count);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (write_enable !== 1'b0) $display("FAIL alu_only_idle: got we=%b, required 0", write_enable);
    else pass_cnt++;
  endtask

  task automatic test_collision;
    mem_valid = 1'b1; mem_destination = 5'd4; mem_data = 32'h11;
    alu_valid = 1'b1; alu_destination = 5'd5; alu_result = 32'h22;
    sb.push_back({5'd4, 32'h11});
    sb.push_back({5'd5, 32'h22});
    tick();
    idle();
    total_cnt++;
    if (!(write_enable === 1'b1 && write_address === 5'd4 && buffer_count === 3'd1))
      $display("FAIL collision_first: got we=%b r%0d count=%0d, required we=1 r4 count=1", write_enable, write_address, buffer_count);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (!(write_enable === 1'b1 && write_address === 5'd5 && buffer_count === 3'd0))
      $display("FAIL collision_second: got we=%b r%0d count=%0d, required we=1 r5 count=0", write_enable, write_address, buffer_count);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_fill;
    logic [AW+DW-1:0] alu_exp [$];
    int acc = 0;
    for (int i = 0; i < 6; i++) begin
      mem_valid = 1'b1; mem_destination = 5'(10 + i); mem_data = 32'h100 + 32'(i);
      alu_valid = 1'b1; alu_destination = 5'(20 + acc); alu_result = 32'h200 + 32'(acc);
      sb.push_back({5'(10 + i), 32'h100 + 32'(i)});
      total_cnt++;
      if (alu_ready !== (i < 4)) $display("FAIL fill_ready_c%0d: got %b, required %b", i, alu_ready, (i < 4));
      else pass_cnt++;
      if (i < 4) begin
        alu_exp.push_back({5'(20 + acc), 32'h200 + 32'(acc)});
        acc++;
      end
      tick();
    end
    idle();
    while (alu_exp.size() != 0) sb.push_back(alu_exp.pop_front());
    for (int k = 0; k < 4; k++) begin
      tick();
      total_cnt++;
      if (!(write_enable === 1'b1 && buffer_count === 3'(3 - k)))
        $display("FAIL fill_drain_%0d: got we=%b count=%0d, required we=1 count=%0d", k, write_enable, buffer_count, 3 - k);
      else pass_cnt++;
    end
    tick();
  endtask

  task automatic test_waw;
    alu_valid = 1'b1; alu_destination = 5'd7; alu_result = 32'h1;
    mem_valid = 1'b1; mem_destination = 5'd8; mem_data = 32'h33;
    sb.push_back({5'd8, 32'h33});
    tick();
    // Load to r7 squashes the buffered r7 entry and the same-cycle ALU r7 offer.
    alu_valid = 1'b1; alu_destination = 5'd7; alu_result = 32'h5;
    mem_valid = 1'b1; mem_destination = 5'd7; mem_data = 32'h9;
    sb.push_back({5'd7, 32'h9});
    tick();
    idle();
    total_cnt++;
    if (buffer_count !== 3'd2) $display("FAIL waw_count: got %0d, required 2", buffer_count);
    else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      tick();
      total_cnt++;
      if (write_enable !== 1'b0) $display("FAIL waw_squash_%0d: got we=%b, required 0", k, write_enable);
      else pass_cnt++;
    end
    total_cnt++;
    if (buffer_count !== 3'd0) $display("FAIL waw_drained: got %0d, required 0", buffer_count);
    else pass_cnt++;
  endtask

  task automatic test_x0_flush;
    alu_valid = 1'b1; alu_destination = 5'd0; alu_result = 32'hDEAD;
    tick();
    idle();
    total_cnt++;
    if (write_enable !== 1'b0) $display("FAIL x0_write: got we=%b, required 0", write_enable);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      mem_valid = 1'b1; mem_destination = 5'(11 + i); mem_data = 32'h500 + 32'(i);
      alu_valid = 1'b1; alu_destination = 5'(21 + i); alu_result = 32'h600 + 32'(i);
      sb.push_back({5'(11 + i), 32'h500 + 32'(i)});
      tick();
    end
    total_cnt++;
    if (buffer_count !== 3'd3) $display("FAIL flush_prefill: got %0d, required 3", buffer_count);
    else pass_cnt++;
    flush = 1'b1;
    mem_valid = 1'b1; mem_destination = 5'd2; mem_data = 32'h77;
    alu_valid = 1'b1; alu_destination = 5'd25; alu_result = 32'h88;
    sb.push_back({5'd2, 32'h77});
    tick();
    idle();
    total_cnt++;
    if (!(write_enable === 1'b1 && write_address === 5'd2 && buffer_count === 3'd0))
      $display("FAIL flush_mem: got we=%b r%0d count=%0d, required we=1 r2 count=0", write_enable, write_address, buffer_count);
    else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      tick();
      total_cnt++;
      if (write_enable !== 1'b0) $display("FAIL flush_idle_%0d: got we=%b, required 0", k, write_enable);
      else pass_cnt++;
    end
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 3; i++) begin
      mem_valid = 1'b1; mem_destination = 5'(12 + i); mem_data = 32'h300 + 32'(i);
      alu_valid = 1'b1; alu_destination = 5'(24 + i); alu_result = 32'h400 + 32'(i);
      sb.push_back({5'(12 + i), 32'h300 + 32'(i)});
      tick();
    end
    idle();
    // Only the first buffered entry drains before reset; the other two are lost.
    sb.push_back({5'd24, 32'h400});
    tick();
    total_cnt++;
    if (buffer_count !== 3'd2) $display("FAIL rst_pre_count: got %0d, required 2", buffer_count);
    else pass_cnt++;
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    total_cnt++;
    if (!(write_enable === 1'b0 && buffer_count === 3'd0))
      $display("FAIL rst_async: got we=%b count=%0d, required we=0 count=0", write_enable, buffer_count);
    else pass_cnt++;
    repeat (2) tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      total_cnt++;
      if (write_enable !== 1'b0) $display("FAIL rst_after_%0d: got we=%b, required 0", k, write_enable);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_alu_only();
    test_collision();
    test_fill();
    test_waw();
    test_x0_flush();
    test_async_reset();
    repeat (3) tick();
    total_cnt++;
    if (sb.size() != 0) $display("FAIL sb_drained: got %0d pending, required 0", sb.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
